// File: rtl/counter_pkg.sv
// Shared types for the lab counter blocks.
// Provides the countdown_timer FSM state encoding.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// master: start, v, reload, en out; count, busy, done in.
// slave : the mirror image, used by the timer itself.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] v;
  logic             reload;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, v, reload, en,
    input  count, busy, done
  );

  modport slave (
    input  start, v, reload, en,
    output count, busy, done
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: asserts tick on every PRESCALE-th enabled cycle.
// Ports: clk, rst (sync, active-high), clr (zero the phase), en (advance),
//        tick (combinational from the phase register and en).
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;

  // With PRESCALE=1 psc stays 0, so tick degenerates to en.
  assign tick = en && (psc == PSC_LAST);

  // Phase counter; clr wins over counting.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else if (en) begin
      psc <= psc + PSC_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Preloadable down-counter with one-cycle done pulse and optional auto-reload.
// Ports: clk, rst (sync, active-high), bus (countdown_timer_if.slave):
//        start/v/reload load a new count, en pauses counting,
//        count is the registered value, busy marks RUN, done marks EXPIRE.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_q,  load_d;
  logic             reload_q, reload_d;
  logic             busy_q, done_q;
  logic             tick;

  // Phase is discarded on any load and whenever the timer is not running.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.start || (state_q != RUN)),
    .en   (bus.en && (state_q == RUN)),
    .tick (tick)
  );

  // State and datapath registers; busy/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      load_q   <= '0;
      reload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      load_q   <= load_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == EXPIRE);
    end
  end

  // Next-state and datapath update; start overrides every other transition.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_d   = load_q;
    reload_d = reload_q;

    if (bus.start) begin
      count_d  = bus.v;
      load_d   = bus.v;
      reload_d = bus.reload;
      state_d  = (bus.v != '0) ? RUN : EXPIRE;
    end else begin
      case (state_q)
        RUN: begin
          // count >= 1 in RUN, so the decrement never wraps.
          if (tick && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              state_d = EXPIRE;
            end
          end
        end
        EXPIRE: begin
          if (reload_q) begin
            // A zero reload value re-expires immediately instead of idling in RUN.
            count_d = load_q;
            state_d = (load_q != '0) ? RUN : EXPIRE;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) driven in lockstep and
// compared every cycle against an elapsed-time model, plus directed timing checks.
module tb_countdown_timer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [W-1:0] v;
  logic reload;
  logic en;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W)) b1 ();
  countdown_timer_if #(.WIDTH(W)) b4 ();

  assign b1.start = start;  assign b4.start = start;
  assign b1.v = v;          assign b4.v = v;
  assign b1.reload = reload; assign b4.reload = reload;
  assign b1.en = en;        assign b4.en = en;

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  // Reference model: a load of n lasts n*P enabled running cycles;
  // count is n minus the whole prescale periods elapsed so far.
  int m_mode [2];  // 0 idle, 1 running, 2 expired
  int m_n    [2];
  int m_el   [2];
  int m_rl   [2];

  function automatic int pscale(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int exp_count(input int i);
    return (m_mode[i] == 1) ? (m_n[i] - m_el[i] / pscale(i)) : 0;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_n[i] = 0; m_el[i] = 0; m_rl[i] = 0;
      end else if (start) begin
        m_n[i] = int'(v); m_rl[i] = int'(reload); m_el[i] = 0;
        m_mode[i] = (v != 0) ? 1 : 2;
      end else if (m_mode[i] == 1) begin
        if (en) begin
          m_el[i]++;
          if (m_el[i] == m_n[i] * pscale(i)) m_mode[i] = 2;
        end
      end else if (m_mode[i] == 2) begin
        if (m_rl[i] != 0) begin
          m_el[i] = 0;
          m_mode[i] = (m_n[i] != 0) ? 1 : 2;
        end else begin
          m_mode[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int i, input logic [W-1:0] c, input logic b, input logic d);
    check($sformatf("p%0d.count", pscale(i)), 32'(c), 32'(exp_count(i)));
    check($sformatf("p%0d.busy", pscale(i)), 32'(b), 32'(m_mode[i] == 1));
    check($sformatf("p%0d.done", pscale(i)), 32'(d), 32'(m_mode[i] == 2));
  endtask

  // One clock: apply inputs, advance model at the edge, compare 1 time unit later.
  task automatic cyc(input logic s, input logic [W-1:0] vv, input logic r, input logic e);
    start = s; v = vv; reload = r; en = e;
    @(posedge clk);
    model_step();
    #1;
    check_dut(0, b1.count, b1.busy, b1.done);
    check_dut(1, b4.count, b4.busy, b4.done);
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  int first_done;
  int pulses;
  logic [W-1:0] exp_seq [6];

  initial begin
    rst = 1'b1; start = 1'b0; v = '0; reload = 1'b0; en = 1'b1;

    // Reset, then idle with en high and no start.
    reset_cycles(2);
    check("rst.count", 32'(b1.count), 32'd0);
    check("rst.busy", 32'(b1.busy), 32'd0);
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b0, 1'b1);
    check("idle.done", 32'(b4.done), 32'd0);

    // One-shot v=5 at PRESCALE=1: 5,4,3,2,1,0 then idle.
    cyc(1'b1, 8'd5, 1'b0, 1'b1);
    check("oneshot.first", 32'(b1.count), 32'd5);
    for (int k = 4; k >= 0; k--) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      check("oneshot.seq", 32'(b1.count), 32'(k));
    end
    check("oneshot.done", 32'(b1.done), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("oneshot.idle_done", 32'(b1.done), 32'd0);
    check("oneshot.idle_busy", 32'(b1.busy), 32'd0);

    // PRESCALE=4, v=3, en low for 6 cycles mid-count: done after edge 18.
    cyc(1'b1, 8'd3, 1'b0, 1'b1);
    first_done = -1; pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1'b0, '0, 1'b0, !(k >= 5 && k <= 10));
      if (b4.done) begin
        pulses++;
        if (first_done < 0) first_done = k;
      end
    end
    check("pause.done_edge", 32'(first_done), 32'd18);
    check("pause.pulses", 32'(pulses), 32'd1);

    // Auto-reload v=2: 2,1,0,2,1,0 then one-shot v=4 finishes and idles.
    exp_seq = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0};
    cyc(1'b1, 8'd2, 1'b1, 1'b1);
    check("reload.seq", 32'(b1.count), 32'(exp_seq[0]));
    for (int k = 1; k < 6; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      check("reload.seq", 32'(b1.count), 32'(exp_seq[k]));
      check("reload.done", 32'(b1.done), 32'(k == 2 || k == 5));
    end
    cyc(1'b1, 8'd4, 1'b0, 1'b1);
    first_done = -1; pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      if (b1.done) begin
        pulses++;
        if (first_done < 0) first_done = k;
      end
    end
    check("reload.stop_edge", 32'(first_done), 32'd4);
    check("reload.stop_pulses", 32'(pulses), 32'd1);

    // v=0: done one cycle after start, never busy.
    cyc(1'b1, 8'd0, 1'b0, 1'b1);
    check("zero.done", 32'(b1.done), 32'd1);
    check("zero.busy", 32'(b1.busy), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("zero.after", 32'(b1.done), 32'd0);

    // v=255: no wrap, done after edge 255.
    cyc(1'b1, 8'd255, 1'b0, 1'b1);
    first_done = -1;
    for (int k = 1; k <= 300 && first_done < 0; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      if (b1.done) first_done = k;
    end
    check("max.done_edge", 32'(first_done), 32'd255);
    reset_cycles(1);

    // Restart during RUN: only the new load expires.
    cyc(1'b1, 8'd10, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 8'd7, 1'b0, 1'b1);
    check("restart.count", 32'(b1.count), 32'd7);
    first_done = -1;
    for (int k = 1; k <= 20 && first_done < 0; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      if (b1.done) first_done = k;
    end
    check("restart.done_edge", 32'(first_done), 32'd7);

    // Start during EXPIRE: the pulse stands, then RUN with the new value.
    cyc(1'b1, 8'd2, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("expire.pulse", 32'(b1.done), 32'd1);
    cyc(1'b1, 8'd3, 1'b0, 1'b1);
    check("expire.reload_count", 32'(b1.count), 32'd3);
    check("expire.reload_busy", 32'(b1.busy), 32'd1);

    // Reset mid-RUN: outputs cleared, no done afterwards.
    cyc(1'b0, '0, 1'b0, 1'b1);
    reset_cycles(1);
    check("rstrun.count", 32'(b1.count), 32'd0);
    check("rstrun.busy", 32'(b4.busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      pulses += int'(b1.done) + int'(b4.done);
    end
    check("rstrun.no_done", 32'(pulses), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic s, r, e;
      logic [W-1:0] vv;
      rst = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       vv = 8'd0;
        1:       vv = 8'd255;
        default: vv = W'($urandom_range(1, 20));
      endcase
      r = (vv != 0) && $urandom_range(0, 1) == 1;
      e = ($urandom_range(0, 3) != 0);
      cyc(s, vv, r, e);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Preloadable down-counter: loads a start value, decrements once per prescaled tick to zero, then flags expiry with a one-cycle `done` pulse. It is the counterpart to the lab's enable-driven up-counter: it consumes the same `WIDTH`-bit value (from a switch, rotary encoder or up-counter output) and produces the delay/timeout events the rest of the lab design waits on. An optional auto-reload mode makes it a periodic event generator.

## Interface
- `WIDTH`, 8: count and preload width.
- `PRESCALE`, 1: enabled clock cycles per decrement, ≥1. Internal prescaler width is `$clog2(PRESCALE)`, minimum 1.

- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: load `v`, latch `reload`, begin counting. Sampled every cycle, in every state.
- `v` in `WIDTH`: preload value; sampled only when `start`=1.
- `reload` in 1: auto-reload mode; sampled only when `start`=1.
- `en` in 1: count enable. When low in RUN, the prescaler and count hold (pause).
- `count` out `WIDTH`: current count, registered.
- `busy` out 1: high in RUN.
- `done` out 1: high for exactly the EXPIRE cycle.

## Operation
- States: IDLE, RUN, EXPIRE.
- Internal registers: `load_q` (`WIDTH`), `reload_q` (1), prescaler `psc`.
- Reset: state=IDLE, `count`=0, `psc`=0, `load_q`=0, `reload_q`=0. Therefore `busy`=0 and `done`=0.
- `start`=1 in any state has priority over all other transitions:
  - `count`←`v`, `load_q`←`v`, `reload_q`←`reload`, `psc`←0.
  - Next state RUN if `v`≠0; EXPIRE if `v`=0, with `count`=0.
- IDLE: `count` holds its last value.
- RUN, with `en`=1: tick = (`psc`==`PRESCALE`-1).
  - No tick: `psc`++.
  - Tick: `psc`←0 and `count`←`count`-1.
  - If the decrement makes `count` 0: next state EXPIRE.
- RUN, with `en`=0: `psc` and `count` hold; state stays RUN.
- EXPIRE lasts one cycle; `count`=0 and `done`=1.
  - `reload_q`=1: `count`←`load_q`, `psc`←0, next state RUN.
  - `reload_q`=0: next state IDLE, `count` stays 0.
- Arithmetic: `count` never wraps. Decrement occurs only while `count`≥1, so 0→max is unreachable.
- `busy`/`done` are decoded from the state register (glitch-free, no combinational input path).

## Timing
- `start` sampled at edge 0 with `en` held high, `v`=N>0: `count`=N after edge 0.
  - `count`=0 and `done`=1 after edge N·`PRESCALE`.
  - IDLE (or reload) after edge N·`PRESCALE`+1.
- Each cycle of `en`=0 during RUN delays expiry by one cycle.
- Auto-reload period: N·`PRESCALE`+1 cycles between `done` pulses.
- `start` with `v`=0: `done` high after edge 1 (EXPIRE), no RUN cycles.
- `start` during RUN: restart; the pending expiry is cancelled and the prescaler phase is discarded.
- `start` during EXPIRE: that `done` pulse still completes; the new load overrides reload/IDLE.
- `rst` mid-RUN: the next cycle is fully reset and no `done` is emitted.

## Structure
- Shared package `counter_pkg`: `typedef enum logic [1:0] {IDLE, RUN, EXPIRE} timer_state_t`.
- Sub-module `tick_gen`: parameterised prescaler.
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Output: `tick`, combinational from its register and `en`.
  - For `PRESCALE`=1, `tick`=`en`.
- Top level contains the FSM, `count`, `load_q` and `reload_q`.

## Test plan
- Reset then idle: `rst` for 2 cycles → `count`=0, `busy`=0, `done`=0; holds with `en`=1 and no `start`.
- One-shot, `PRESCALE`=1, `v`=5, `reload`=0, `en`=1 → `count` 5,4,3,2,1,0 on consecutive cycles; `done` high one cycle with `count`=0; then IDLE with `count`=0.
- Prescale and pause, `PRESCALE`=4, `v`=3, `en` low for 6 cycles mid-count → `done` after edge 12+6=18, exactly one pulse.
- Auto-reload, `PRESCALE`=1, `v`=2, `reload`=1 → `done` every 3 cycles; `count` sequence 2,1,0,2,1,0…; `start` with `v`=4, `reload`=0 then gives one more pulse 4 cycles later and IDLE.
- Edge values: `v`=0 → `done` one cycle after `start`, `busy` never high; `v`=255 (`WIDTH`=8) → no wrap, `done` after edge 255.
- Collisions: `start` (`v`=7) during RUN → restart, no `done` from the old load; `start` in EXPIRE → `done` pulse kept, then RUN with `count`=`v`; `rst` in RUN → outputs reset next cycle, no `done`.
